// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master single-outstanding bus arbiter (IDLE/ADDR/DATA) with HREADY timeout; define MEM_ARB_ROUND_ROBIN_EN for round-robin instead of fixed M1 priority
module mem_bus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int AW = 64
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  output logic          m0_done,
  output logic [AW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_write,
  input  logic [AW-1:0] m1_addr,
  input  logic [AW-1:0] m1_wdata,
  output logic          m1_done,
  output logic [AW-1:0] m1_rdata,
  output logic [AW-1:0] HADDR,
  output logic [AW-1:0] HWDATA,
  output logic          HWRITE,
  output logic          HTRANS,
  input  logic          HREADY,
  input  logic [AW-1:0] HRDATA,
  output logic          bus_err,
  output logic          stall
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_nx;
  logic owner, prio_m1, grant_m1, start, fin, abort;
  logic [7:0] wait_cnt;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic ptr_m1;
  always_ff @(posedge CLK) ptr_m1 <= RST ? 1'b1 : start ? !grant_m1 : ptr_m1;
  assign prio_m1 = ptr_m1;
`else
  assign prio_m1 = 1'b1;
`endif
  always_comb begin
    start = state == IDLE && (m0_req || m1_req);
    grant_m1 = m1_req && (!m0_req || prio_m1);
    fin = state == DATA && HREADY;
    abort = state == DATA && !HREADY && wait_cnt == 8'(TIMEOUT - 1);
    state_nx = state == IDLE ? (start ? ADDR : IDLE) : state == ADDR ? DATA : (fin || abort) ? IDLE : DATA;
  end
  always_ff @(posedge CLK) state <= RST ? IDLE : state_nx;
  assign stall = (m0_req && !m0_done) || (m1_req && !m1_done);
  always_ff @(posedge CLK) begin
    if (RST) begin
      owner <= 1'b0;
      HTRANS <= 1'b0;
      HWRITE <= 1'b0;
      HADDR <= '0;
      HWDATA <= '0;
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      bus_err <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      wait_cnt <= '0;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      bus_err <= 1'b0;
      if (start) begin
        owner <= grant_m1;
        HTRANS <= 1'b1;
        HADDR <= grant_m1 ? m1_addr : m0_addr;
        HWRITE <= grant_m1 && m1_write;
        if (grant_m1 && m1_write) HWDATA <= m1_wdata;
        wait_cnt <= '0;
      end
      if (state == ADDR) HTRANS <= 1'b0;
      if (state == DATA && !HREADY) wait_cnt <= wait_cnt + 8'd1;
      if (fin || abort) begin
        m0_done <= !owner;
        m1_done <= owner;
        bus_err <= abort;
      end
      if (fin && !owner) m0_rdata <= HRDATA;
      if (fin && owner) m1_rdata <= HRDATA;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: transaction-level randomized self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  localparam int TO = 8;
  localparam int AW = 64;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic m0_req = 1'b0, m1_req = 1'b0, m1_write = 1'b0, HREADY = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0, m1_wdata = '0, HRDATA = '0;
  logic m0_done, m1_done, HWRITE, HTRANS, bus_err, stall;
  logic [AW-1:0] m0_rdata, m1_rdata, HADDR, HWDATA;
  int checks = 0, failures = 0;
  bit prio_m1 = 1'b1;
  logic [AW-1:0] exp_hwdata = '0, exp_rd0 = '0, exp_rd1 = '0;
  always #5 CLK = ~CLK;
  mem_bus_arbiter #(.TIMEOUT(TO), .AW(AW)) dut (
    .CLK(CLK), .RST(RST),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_done(m1_done), .m1_rdata(m1_rdata),
    .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HTRANS(HTRANS),
    .HREADY(HREADY), .HRDATA(HRDATA), .bus_err(bus_err), .stall(stall)
  );
  task automatic txn(input bit r0, input bit r1, input bit w, input logic [AW-1:0] a0,
                     input logic [AW-1:0] a1, input logic [AW-1:0] wd, input int lo, input bit drop);
    bit win1, err, ew, done_now;
    int d;
    logic [AW-1:0] ea, hr;
    logic [5:0] ctl, exp_ctl;
    win1 = r1 && (!r0 || prio_m1);
    if (RR) prio_m1 = !win1;
    d = 2 + (lo < TO ? lo : TO - 1);
    err = lo >= TO;
    ea = win1 ? a1 : a0;
    ew = win1 && w;
    if (ew) exp_hwdata = wd;
    m0_req = r0; m1_req = r1; m1_write = w; m0_addr = a0; m1_addr = a1; m1_wdata = wd;
    for (int n = 0; n <= d; n++) begin
      HREADY = n >= 2 + lo;
      hr = {$urandom, $urandom};
      HRDATA = hr;
      @(negedge CLK);
      done_now = n == d;
      if (done_now && !err) begin
        if (win1) exp_rd1 = hr;
        else exp_rd0 = hr;
      end
      ctl = {m0_done, m1_done, bus_err, HTRANS, HWRITE, stall};
      exp_ctl = {done_now && !win1, done_now && win1, done_now && err, n == 0, ew,
                 (m0_req && !(done_now && !win1)) || (m1_req && !(done_now && win1))};
      checks += 5;
      if (ctl !== exp_ctl) begin
        failures++;
        $display("FAIL ctl[m0_done,m1_done,bus_err,htrans,hwrite,stall] cyc=%0d got=%b exp=%b", n, ctl, exp_ctl);
      end
      if (HADDR !== ea) begin
        failures++;
        $display("FAIL haddr cyc=%0d got=%h exp=%h", n, HADDR, ea);
      end
      if (HWDATA !== exp_hwdata) begin
        failures++;
        $display("FAIL hwdata cyc=%0d got=%h exp=%h", n, HWDATA, exp_hwdata);
      end
      if (m0_rdata !== exp_rd0) begin
        failures++;
        $display("FAIL m0_rdata cyc=%0d got=%h exp=%h", n, m0_rdata, exp_rd0);
      end
      if (m1_rdata !== exp_rd1) begin
        failures++;
        $display("FAIL m1_rdata cyc=%0d got=%h exp=%h", n, m1_rdata, exp_rd1);
      end
      if (n == 0 && drop) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
    end
  endtask
  task automatic idle(input int k);
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (k) @(negedge CLK);
  endtask
  task automatic check_reset_values(input string tag);
    logic [AW*4+4:0] got;
    got = {HTRANS, HWRITE, m0_done, m1_done, bus_err, HADDR, HWDATA, m0_rdata, m1_rdata};
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL %s got=%h exp=0", tag, got);
    end
  endtask
  task automatic test_reset;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check_reset_values("reset_state");
    RST = 1'b0;
    prio_m1 = 1'b1; exp_hwdata = '0; exp_rd0 = '0; exp_rd1 = '0;
    @(negedge CLK);
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL idle_stall got=%b exp=0", stall);
    end
  endtask
  task automatic test_m0_single;
    txn(1'b1, 1'b0, 1'b0, 64'h1000, 64'h0, 64'h0, 0, 1'b0);
    idle(2);
  endtask
  task automatic test_m1_write_wait;
    txn(1'b0, 1'b1, 1'b1, 64'h0, 64'h2008, 64'hDEADBEEF, 4, 1'b0);
    idle(1);
    txn(1'b1, 1'b0, 1'b0, 64'h3000, 64'h0, 64'h0, 2, 1'b0);
    idle(1);
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++)
      txn(1'b1, 1'b1, i[0], 64'h4000 + 64'(i), 64'h5000 + 64'(i), {$urandom, $urandom}, $urandom_range(0, 2), 1'b0);
    idle(2);
  endtask
  task automatic test_timeout;
    txn(1'b0, 1'b1, 1'b0, 64'h0, 64'h6000, 64'h0, TO - 1, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 64'h0, 64'h6008, 64'h0, TO, 1'b0);
    idle(1);
    txn(1'b1, 1'b0, 1'b0, 64'h7000, 64'h0, 64'h0, TO + 3, 1'b0);
    idle(1);
  endtask
  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(1, 3);
      txn(r[0], r[1], 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
          $urandom_range(0, 10), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
  endtask
  task automatic test_reset_mid;
    m1_req = 1'b1; m1_write = 1'b1; m1_addr = 64'h8000; m1_wdata = 64'h1234; HREADY = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    m1_req = 1'b0;
    @(negedge CLK);
    check_reset_values("reset_mid");
    RST = 1'b0;
    prio_m1 = 1'b1; exp_hwdata = '0; exp_rd0 = '0; exp_rd1 = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if ({m0_done, m1_done, bus_err, HTRANS} !== 4'b0) begin
        failures++;
        $display("FAIL post_reset_quiet cyc=%0d got=%b exp=0000", i, {m0_done, m1_done, bus_err, HTRANS});
      end
    end
    txn(1'b1, 1'b1, 1'b1, 64'h9000, 64'h9008, 64'hCAFE, 1, 1'b0);
    idle(1);
  endtask
  initial begin
    test_reset;
    test_m0_single;
    test_m1_write_wait;
    test_back_to_back;
    test_timeout;
    test_random;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
